delay_unit: RTL and testbench
=============================

DELAY_UNIT -- requirements
Module: delay_unit

Interface
REQ-001 Parameter DELAY_CYCLES, default 8: clk cycles both inputs must stay high before out asserts; legal range 1..255.
REQ-002 Parameter SYNC_STAGES, default 2: flop stages in the input synchronizer; legal range 2..4.
REQ-003 Parameter CNT_W, default 8: counter width; SHALL satisfy 2^CNT_W > DELAY_CYCLES.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 planBreset  input  1  reset, asynchronous, active-high.
REQ-006 in1  input  1  arm request ("plan B armed"); asynchronous to clk.
REQ-007 in2  input  1  enable; high while the monitored event is still pending, low once it completes; asynchronous to clk.
REQ-008 out  output  1  timeout flag; registered, glitch-free.

Function
REQ-009 arm = in1 AND in2, formed combinationally, then passed through SYNC_STAGES flops; last stage is arm_s.
REQ-010 Counter cnt (CNT_W bits): when arm_s=1 and cnt<DELAY_CYCLES, cnt increments by 1 each edge.
REQ-011 cnt saturates at DELAY_CYCLES and never wraps while arm_s stays 1.
REQ-012 arm_s=0 on any edge clears cnt to 0 on that edge.
REQ-013 out SHALL be 1 exactly when registered cnt == DELAY_CYCLES; otherwise out SHALL be 0.
REQ-014 Assert latency: arm first sampled high at edge 1 and held -> out rises at edge SYNC_STAGES+DELAY_CYCLES (10 with defaults).
REQ-015 Deassert latency: arm first sampled low at edge k -> out falls at edge k+SYNC_STAGES.
REQ-016 Any low pulse of arm captured by the synchronizer restarts the count from 0; no partial credit is kept.
REQ-017 Pulses shorter than one clk period may be missed; such pulses are not timeouts.
REQ-018 out stays high as long as arm_s remains 1; it is a level, not a pulse.
REQ-019 in1 and in2 changing on the same edge act only through their AND; no ordering dependency.

Reset
REQ-020 planBreset=1 asynchronously forces all synchronizer stages, cnt and out to 0, with no clock edge needed.
REQ-021 While planBreset=1, out SHALL hold 0 regardless of in1, in2 or clk.
REQ-022 After reset release, counting restarts from 0; the first edge may sample arm.
REQ-023 Reset asserted mid-count or while out=1 discards all progress; out drops at once.

Structure
REQ-024 DELAY_CYCLES, SYNC_STAGES and CNT_W defaults SHALL live in shared package delay_pkg with the counter typedef.
REQ-025 One sub-module, sync_bit (SYNC_STAGES-deep synchronizer with async reset), SHALL be instantiated for arm.
REQ-026 Compile-time checks SHALL reject DELAY_CYCLES=0, SYNC_STAGES<2, and CNT_W too small.

Verification (defaults: SYNC_STAGES=2, DELAY_CYCLES=8)
REQ-027 in1=in2=1 from before edge 1, held -> out=0 through edge 9, out=1 at edge 10, stays 1 to edge 30.
REQ-028 in1=1, in2=0 for 50 cycles -> out=0 throughout, cnt=0.
REQ-029 out=1, then in2 drops before edge 20 -> out=1 at edge 21, out=0 at edge 22.
REQ-030 Armed at edge 1, in2 low for one full cycle at edge 5, high again -> out rises at edge 16, not 10.
REQ-031 Armed, planBreset pulses high at edge 6 for 2 cycles -> out=0 immediately; released before edge 8, arm held -> out rises at edge 17.
REQ-032 Armed 200 cycles -> out stays 1 and cnt stays 8 (no wrap).

Source files
------------

// File: rtl/delay_pkg.sv
// Shared defaults and counter type for the plan-B delay timer.
package delay_pkg;

  localparam int DELAY_CYCLES_DEF = 8;
  localparam int SYNC_STAGES_DEF  = 2;
  localparam int CNT_W_DEF        = 8;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // True when a CNT_W-bit counter can hold the terminal count without wrapping.
  function automatic bit cnt_fits(input int cnt_w, input int delay);
    if (cnt_w >= 31) return 1'b1;
    return (delay < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchronizer with asynchronous active-high clear.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic planBreset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge planBreset) begin
    if (planBreset) ff <= '0;
    else            ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/delay_unit.sv
// Plan-B timeout: out asserts once in1 & in2 have been held high for DELAY_CYCLES
// synchronized clk cycles, and drops as soon as the synchronized arm falls.
module delay_unit
  import delay_pkg::*;
#(
  parameter int DELAY_CYCLES = DELAY_CYCLES_DEF,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic planBreset,
  input  logic in1,
  input  logic in2,
  output logic out
);

  if (DELAY_CYCLES < 1 || DELAY_CYCLES > 255) begin : g_bad_delay
    $error("delay_unit: DELAY_CYCLES must be within 1..255");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("delay_unit: SYNC_STAGES must be within 2..4");
  end
  if (!cnt_fits(CNT_W, DELAY_CYCLES)) begin : g_bad_cnt_w
    $error("delay_unit: CNT_W too small for DELAY_CYCLES");
  end

  localparam logic [CNT_W-1:0] TC = CNT_W'(DELAY_CYCLES);

  logic             arm;
  logic             arm_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Only the AND is synchronized, so simultaneous in1/in2 changes cannot race.
  assign arm = in1 & in2;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync_arm (
    .clk       (clk),
    .planBreset(planBreset),
    .d         (arm),
    .q         (arm_s)
  );

  always_comb begin
    cnt_nxt = cnt;
    if (!arm_s)        cnt_nxt = '0;
    else if (cnt < TC) cnt_nxt = cnt + CNT_W'(1);
  end

  // out is decoded from the next count so it is a clean flop output in the
  // same cycle cnt reaches the terminal value.
  always_ff @(posedge clk or posedge planBreset) begin
    if (planBreset) begin
      cnt <= '0;
      out <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      out <= (cnt_nxt == TC);
    end
  end

endmodule

// File: tb/tb_delay_unit.sv
// Directed bench for delay_unit at default parameters (SYNC_STAGES=2, DELAY_CYCLES=8).
module tb_delay_unit;

  logic clk = 1'b0;
  logic planBreset = 1'b1;
  logic in1 = 1'b0;
  logic in2 = 1'b0;
  logic out;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  delay_unit dut (
    .clk       (clk),
    .planBreset(planBreset),
    .in1       (in1),
    .in2       (in2),
    .out       (out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Holds reset with the given inputs, releases at a falling edge; the next
  // rising edge is edge 1.
  task automatic start_run(input logic i1, input logic i2);
    planBreset = 1'b1;
    in1 = i1;
    in2 = i2;
    @(negedge clk);
    @(negedge clk);
    planBreset = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset holds everything low even with both inputs high and clk running
    planBreset = 1'b1;
    in1 = 1'b1;
    in2 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("rst_out", out, 0);
    end
    check("rst_cnt", dut.cnt, 0);

    // basic assert latency and level hold
    start_run(1'b1, 1'b1);
    for (int e = 1; e <= 30; e++) begin
      tick();
      check($sformatf("lat_out_e%0d", e), out, (e >= 10) ? 1 : 0);
      if (e == 10) check("lat_cnt_e10", dut.cnt, 8);
    end

    // in2 drops before edge 20 -> still high at 21, low at 22
    start_run(1'b1, 1'b1);
    for (int e = 1; e <= 24; e++) begin
      tick();
      check($sformatf("deas_out_e%0d", e), out, (e >= 10 && e <= 21) ? 1 : 0);
      if (e == 19) in2 = 1'b0;
    end
    check("deas_cnt", dut.cnt, 0);

    // one-cycle low gap sampled at edge 6 restarts the count
    start_run(1'b1, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("gap_out_e%0d", e), out, (e >= 16) ? 1 : 0);
      if (e == 5) in2 = 1'b0;
      if (e == 6) in2 = 1'b1;
    end

    // reset pulse mid-count discards progress
    start_run(1'b1, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      tick();
      check($sformatf("rstmid_out_e%0d", e), out, (e >= 17) ? 1 : 0);
      if (e == 5) begin
        @(negedge clk);
        planBreset = 1'b1;
        #1;
        check("rstmid_cnt_async", dut.cnt, 0);
      end
      if (e == 7) begin
        @(negedge clk);
        planBreset = 1'b0;
      end
    end

    // reset while out is high drops out without a clock edge
    start_run(1'b1, 1'b1);
    for (int e = 1; e <= 12; e++) tick();
    check("rsthi_out_before", out, 1);
    #2 planBreset = 1'b1;
    #1;
    check("rsthi_out_async", out, 0);
    check("rsthi_cnt_async", dut.cnt, 0);

    // in1 alone never arms
    start_run(1'b1, 1'b0);
    for (int e = 1; e <= 50; e++) begin
      tick();
      check($sformatf("noarm_out_e%0d", e), out, 0);
    end
    check("noarm_cnt", dut.cnt, 0);

    // in1 and in2 swap on the same edge: AND stays low, no count
    start_run(1'b0, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 3) begin
        in1 = 1'b1;
        in2 = 1'b0;
      end
      check($sformatf("swap_out_e%0d", e), out, 0);
    end
    check("swap_cnt", dut.cnt, 0);

    // long hold saturates, never wraps
    start_run(1'b1, 1'b1);
    for (int e = 1; e <= 200; e++) begin
      tick();
      check($sformatf("sat_out_e%0d", e), out, (e >= 10) ? 1 : 0);
      if (e % 50 == 0) check($sformatf("sat_cnt_e%0d", e), dut.cnt, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
